// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD 7-segment scanner.
// Segment bit order is gfedcba: bit 0 = segment a, bit 6 = segment g.
package bcd_disp_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage : bcd_disp_pkg

// File: rtl/bcd_seg_scan_if.sv
// Display-side bus of bcd_seg_scan: digit/decimal-point inputs, load and
// scan-enable controls, and the multiplexed segment/digit outputs.
// The master drives the inputs and observes the display; the slave is the scanner.
interface bcd_seg_scan_if
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  logic                      ena;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic                      load;
  logic [NUM_DIGITS-1:0]     dp_in;
  seg_t                      seg_out;
  logic                      dp_out;
  logic [NUM_DIGITS-1:0]     dig_sel;
  logic                      frame_done;

  modport master (
    output ena, digits_in, load, dp_in,
    input  seg_out, dp_out, dig_sel, frame_done
  );

  modport slave (
    input  ena, digits_in, load, dp_in,
    output seg_out, dp_out, dig_sel, frame_done
  );

endinterface : bcd_seg_scan_if

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder. Non-decimal codes 10..15 show a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  // Map one BCD code to its gfedcba segment pattern.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via
    // default) so no latch is inferred.
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule : bcd_to_seg7

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-segment scanner for a packed BCD count.
// A shadow register captures digits on load; the display register is refreshed
// from the shadow only at the end of a full scan, so a frame never mixes values.
// Each digit slot lasts PRESCALE cycles, the first BLANK_CYCLES of which are
// dark to suppress ghosting. All display outputs come straight from flops.
// Optional build macro LZB_EN enables leading-zero blanking.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 1,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_seg_scan_if.slave    bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PW:0]   BLANK_LIM  = (PW+1)'(BLANK_CYCLES);

  // Electrical "off" levels, folded into the flops so outputs stay glitch-free.
  localparam logic                  POL      = (ACTIVE_LOW != 0);
  localparam seg_t                  SEG_OFF  = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{POL}};

  // Scan position.
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;

  // Shadow (load side) and display (scan side) copies of digits and points.
  bcd_t [NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0] shadow_dp_q;
  bcd_t [NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  // Registered outputs.
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic slot_end;
  logic frame_end;
  logic in_blank;
  bcd_t cur_digit;
  seg_t cur_seg;

  // Marks digits hidden by leading-zero blanking: a digit is hidden when it and
  // every more-significant digit are zero; digit 0 always stays visible.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
    input bcd_t [NUM_DIGITS-1:0] d
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (d[i] == 4'd0);
      mask[i]  = zero_run;
    end
    return mask;
  endfunction

  assign slot_end  = (presc_q == PRESC_LAST);
  assign frame_end = bus.ena && slot_end && (idx_q == IDX_LAST);
  assign in_blank  = ({1'b0, presc_q} < BLANK_LIM);
  assign cur_digit = disp_q[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  // Next scan position: the prescaler and index advance only while enabled.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (bus.ena) begin
      if (slot_end) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Display refresh at the frame boundary; a same-cycle load bypasses the shadow.
  always_comb begin
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    if (frame_end) begin
      if (bus.load) begin
        disp_d    = bus.digits_in;
        disp_dp_d = bus.dp_in;
      end else begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
    end
`ifdef LZB_EN
    blank_d = lead_zero_mask(disp_d);
`else
    blank_d = '0;
`endif
  end

  // Next output values: dark during blanking or while the scan is disabled.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    dig_d = '0;
    if (bus.ena && !in_blank) begin
      dig_d = NUM_DIGITS'(1) << idx_q;
      seg_d = blank_q[idx_q] ? SEG_BLANK : cur_seg;
      dp_d  = disp_dp_q[idx_q];
    end
    seg_d = seg_d ^ SEG_OFF;
    dp_d  = dp_d ^ POL;
    dig_d = dig_d ^ DIG_OFF;
  end

  // Scan position and digit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      // NOTE: the digit stores are a handful of flops, so they are reset to
      // give a defined first frame instead of being left uninitialised.
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      blank_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      blank_q   <= blank_d;
      if (bus.load) begin
        shadow_q    <= bus.digits_in;
        shadow_dp_q <= bus.dp_in;
      end
    end
  end

  // Output registers, reset to the electrically inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= POL;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = frame_end;

endmodule : bcd_seg_scan

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1).
// The reference model tracks the scan as a count of enabled cycles and derives
// slot/phase with division and modulo. Honours LZB_EN if defined.
module tb_bcd_seg_scan;

  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_seg_scan_if #(.NUM_DIGITS(N)) bus ();

  bcd_seg_scan #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (B),
    .ACTIVE_LOW   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int         pos;
  logic [3:0] sh_dig [N];
  logic [3:0] ds_dig [N];
  bit         sh_dp  [N];
  bit         ds_dp  [N];
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [N-1:0] exp_dig;

  int cyc     = 0;
  int fd_last = -1;
  int fd_prev = -1;
  bit fd_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic bit hidden(input int i);
`ifdef LZB_EN
    if (i == 0) return 1'b0;
    for (int j = i; j < N; j++) if (ds_dig[j] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return (i < 0);
`endif
  endfunction

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < N; i++) begin
      sh_dig[i] = 4'd0; ds_dig[i] = 4'd0; sh_dp[i] = 1'b0; ds_dp[i] = 1'b0;
    end
    exp_seg = 7'h00; exp_dp = 1'b0; exp_dig = '0;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit en, input bit ld, input logic [15:0] d, input logic [3:0] dp);
    int slot, ph;
    bit bnd;
    check("seg_out", bus.seg_out, exp_seg);
    check("dig_sel", bus.dig_sel, exp_dig);
    check("dp_out", bus.dp_out, exp_dp);
    bus.ena = en; bus.load = ld; bus.digits_in = d; bus.dp_in = dp;
    #1;
    slot = (pos / P) % N;
    ph   = pos % P;
    bnd  = en && (ph == P - 1) && (slot == N - 1);
    check("frame_done", bus.frame_done, bnd);
    fd_hit = bus.frame_done;
    if (bus.frame_done) begin
      fd_prev = fd_last;
      fd_last = cyc;
    end
    @(posedge clk);
    if (en && ph >= B) begin
      exp_dig = N'(1) << slot;
      exp_seg = hidden(slot) ? 7'h00 : seg_ref(ds_dig[slot]);
      exp_dp  = ds_dp[slot];
    end else begin
      exp_dig = '0; exp_seg = 7'h00; exp_dp = 1'b0;
    end
    if (bnd) begin
      for (int i = 0; i < N; i++) begin
        ds_dig[i] = ld ? d[4*i +: 4] : sh_dig[i];
        ds_dp[i]  = ld ? dp[i] : sh_dp[i];
      end
    end
    if (ld) for (int i = 0; i < N; i++) begin
      sh_dig[i] = d[4*i +: 4];
      sh_dp[i]  = dp[i];
    end
    if (en) pos++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'(($urandom)), 4'($urandom));
  endtask

  task automatic wait_fd(input string tag);
    fd_hit = 1'b0;
    for (int i = 0; i < 40 && !fd_hit; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    check(tag, fd_hit, 1'b1);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; entered at a falling edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_seg"}, bus.seg_out, 7'h00);
    check({tag, "_dig"}, bus.dig_sel, 4'h0);
    check({tag, "_dp"}, bus.dp_out, 1'b0);
    check({tag, "_fd"}, bus.frame_done, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", bus.seg_out, 7'h00);
    check("rst_dig", bus.dig_sel, 4'h0);
    check("rst_dp", bus.dp_out, 1'b0);
    check("rst_fd", bus.frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed loads from the bring-up plan.
    step(1'b1, 1'b1, 16'h1234, 4'h0);
    run(40);
    step(1'b1, 1'b1, 16'h5678, 4'h0);
    run(40);
    step(1'b1, 1'b1, 16'h9ABC, 4'h0);
    run(36);
    step(1'b1, 1'b1, 16'h0070, 4'h1);
    run(40);

    // Ten disabled cycles mid-slot stretch the frame by exactly ten cycles.
    wait_fd("fd_before_pause");
    run(5);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    wait_fd("fd_after_pause");
    check("frame_len", 32'(fd_last - fd_prev), 32'(N * P + 10));

    // Undisturbed frame length.
    wait_fd("fd_plain");
    check("frame_len_plain", 32'(fd_last - fd_prev), 32'(N * P));

    // Reset mid-slot, then restart from digit 0.
    step(1'b1, 1'b1, 16'h4321, 4'hA);
    run(18);
    async_reset("rst_mid");
    run(40);

    // Randomized traffic, including non-BCD codes and enable gaps.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           16'($urandom), 4'($urandom));
    async_reset("rst_rand");
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
           16'($urandom), 4'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bcd_seg_scan
